// File: rtl/ram4x8_host_ctrl.sv
// Host-side initiator for a 4-byte x 8-bit RAM: valid/ready request channel in,
// registered RAM pin sequencing out, captured read data on a valid/ready response channel.
module ram4x8_host_ctrl #(
  parameter int WR_PULSE  = 2,
  parameter int RD_WAIT   = 2,
  parameter int CLR_PULSE = 2
) (
  input  logic       Clock,
  input  logic       Clear,
  input  logic       ReqValid,
  output logic       ReqReady,
  input  logic [1:0] ReqOp,
  input  logic [1:0] ReqAddr,
  input  logic [7:0] ReqData,
  output logic       RspValid,
  input  logic       RspReady,
  output logic [7:0] RspData,
  output logic [7:0] RamI,
  output logic [1:0] RamSelect,
  output logic       RamRead,
  output logic       RamClear,
  input  logic [7:0] RamO
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WR_SETUP   = 3'd1;
  localparam logic [2:0] S_WR_STROBE  = 3'd2;
  localparam logic [2:0] S_WR_HOLD    = 3'd3;
  localparam logic [2:0] S_RD_WAIT    = 3'd4;
  localparam logic [2:0] S_RD_CAPTURE = 3'd5;
  localparam logic [2:0] S_CLR        = 3'd6;

  localparam logic [3:0] WR_LOAD  = 4'(WR_PULSE - 1);
  localparam logic [3:0] RD_LOAD  = 4'(RD_WAIT - 1);
  localparam logic [3:0] CLR_LOAD = 4'(CLR_PULSE - 1);

  logic [2:0] state_r;
  logic [3:0] cnt_r;

  // RamClear is only low in IDLE straight after reset, which keeps ReqReady low until the first released edge.
  assign ReqReady = (state_r == S_IDLE) && !RspValid && RamClear;

  // Sequencer: state, timing counter, response register and all registered RAM pins.
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state_r   <= S_IDLE;
      cnt_r     <= 4'd0;
      RspValid  <= 1'b0;
      RspData   <= 8'h00;
      RamI      <= 8'h00;
      RamSelect <= 2'b00;
      RamRead   <= 1'b1;
      RamClear  <= 1'b0;
    end else begin
      if (state_r != S_CLR) begin
        RamClear <= 1'b1;
      end
      if (RspValid && RspReady) begin
        RspValid <= 1'b0;
      end
      case (state_r)
        S_IDLE: begin
          if (ReqValid && ReqReady) begin
            if (ReqOp[1]) begin
              state_r  <= S_CLR;
              cnt_r    <= CLR_LOAD;
              RamClear <= 1'b0;
            end else if (ReqOp[0]) begin
              state_r   <= S_WR_SETUP;
              RamSelect <= ReqAddr;
              RamI      <= ReqData;
            end else begin
              state_r   <= S_RD_WAIT;
              cnt_r     <= RD_LOAD;
              RamSelect <= ReqAddr;
            end
          end
        end
        S_WR_SETUP: begin
          state_r <= S_WR_STROBE;
          cnt_r   <= WR_LOAD;
          RamRead <= 1'b0;
        end
        S_WR_STROBE: begin
          if (cnt_r == 4'd0) begin
            state_r <= S_WR_HOLD;
            RamRead <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_WR_HOLD: begin
          state_r <= S_IDLE;
        end
        S_RD_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= S_RD_CAPTURE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_RD_CAPTURE: begin
          RspData  <= RamO;
          RspValid <= 1'b1;
          state_r  <= S_IDLE;
        end
        S_CLR: begin
          if (cnt_r == 4'd0) begin
            state_r  <= S_IDLE;
            RamClear <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r  <= S_IDLE;
          RamRead  <= 1'b1;
          RamClear <= 1'b1;
        end
      endcase
    end
  end

endmodule
